// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REQ      = 2'b01,
    ST_WAIT_RSP = 2'b10,
    ST_DONE     = 2'b11
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_SIZE     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request checks on the live inputs, store lane
// replication / byte enables and load extraction on the captured access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        chk_we,
  input  logic [2:0]  chk_funct3,
  input  logic [1:0]  chk_addr_lo,
  output logic        bad_size,
  output logic        misalign,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [31:0] wdata_lanes,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Size legality and natural alignment of the incoming request
  always_comb begin
    if (chk_we) bad_size = (chk_funct3 > F3_W);
    else        bad_size = (chk_funct3 == 3'b011) || (chk_funct3 == 3'b110) ||
                           (chk_funct3 == 3'b111);
    case (chk_funct3)
      F3_H, F3_HU: misalign = chk_addr_lo[0];
      F3_W:        misalign = (chk_addr_lo != 2'b00);
      default:     misalign = 1'b0;
    endcase
  end

  // Replicate store data across lanes and enable only the addressed bytes
  always_comb begin
    wdata_lanes = wdata;
    wstrb       = 4'b1111;
    case (funct3)
      F3_B: begin
        wdata_lanes = {4{wdata[7:0]}};
        wstrb       = 4'b0001 << addr_lo;
      end
      F3_H: begin
        wdata_lanes = {2{wdata[15:0]}};
        wstrb       = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: wstrb = 4'b1111;
    endcase
    if (!we) wstrb = 4'b0000;
  end

  // Pick the addressed byte/halfword from the read word and extend it
  always_comb begin
    byte_sel = rdata_raw[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    case (funct3)
      F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_ext = {24'b0, byte_sel};
      F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_ext = {16'b0, half_sel};
      default: rdata_ext = rdata_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one mem_read/mem_write into a single valid/ready bus
// transaction, stalling the pipeline until it completes, faults or times out.
//
//   state       | meaning
//   ST_IDLE     | waiting for a request; faulting requests are reported here
//   ST_REQ      | bus_req_valid high, waiting for bus_req_ready
//   ST_WAIT_RSP | request accepted, waiting for bus_rsp_valid
//   ST_DONE     | one cycle: load_valid or timeout fault, pipeline released
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            load_valid,
  output logic [XLEN-1:0] rdata,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rdata
);

  lsu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic            we_q, to_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic            bad_size, misalign, req, req_fault, req_ok, timeout_hit;
  logic [XLEN-1:0] wdata_lanes, rdata_ext;
  logic [3:0]      wstrb;

  assign req         = mem_read | mem_write;
  assign req_fault   = req & (bad_size | misalign);
  assign req_ok      = req & ~(bad_size | misalign);
  // Hit on the last counted cycle so DONE follows exactly TIMEOUT_CYCLES cycles
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Write wins when both strobes are high, so mem_write alone selects the op
  lsu_align u_align (
    .chk_we      (mem_write),
    .chk_funct3  (funct3),
    .chk_addr_lo (addr[1:0]),
    .bad_size    (bad_size),
    .misalign    (misalign),
    .we          (we_q),
    .funct3      (f3_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata_raw   (bus_rdata),
    .wdata_lanes (wdata_lanes),
    .wstrb       (wstrb),
    .rdata_ext   (rdata_ext)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a response in the final counted cycle still completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (req_ok) state_d = ST_REQ;
      ST_REQ: begin
        if (timeout_hit)        state_d = ST_DONE;
        else if (bus_req_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: if (bus_rsp_valid || timeout_hit) state_d = ST_DONE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Capture the access, run the timeout counter and latch load results
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      to_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_ok) begin
            cnt_q   <= '0;
            we_q    <= mem_write;
            to_q    <= 1'b0;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (timeout_hit) to_q <= 1'b1;
        end
        ST_WAIT_RSP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus_rsp_valid) begin
            if (!we_q) rdata_q <= rdata_ext;
          end else if (timeout_hit) begin
            to_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs; the IDLE terms are combinational on inputs, so reset forces them low
  always_comb begin
    stall         = 1'b0;
    load_valid    = 1'b0;
    fault         = 1'b0;
    fault_cause   = CAUSE_NONE;
    bus_req_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_fault) begin
          fault       = 1'b1;
          fault_cause = bad_size ? CAUSE_SIZE : CAUSE_MISALIGN;
        end else if (req_ok) begin
          stall = 1'b1;
        end
      end
      ST_REQ: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
      end
      ST_WAIT_RSP: stall = 1'b1;
      default: begin
        if (to_q) begin
          fault       = 1'b1;
          fault_cause = CAUSE_TIMEOUT;
        end else begin
          load_valid = ~we_q;
        end
      end
    endcase
    if (!reset_n) begin
      stall       = 1'b0;
      fault       = 1'b0;
      fault_cause = CAUSE_NONE;
    end
  end

  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign bus_wdata = wdata_lanes;
  assign bus_wstrb = wstrb;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table driven through a small bus model,
// expected results queued at drive time and popped when the access finishes.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, load_valid, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_cause;
  logic        bus_req_valid, bus_we;
  logic        bus_req_ready = 1'b0, bus_rsp_valid = 1'b0;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic [3:0]  bus_wstrb;

  always #5 clock = ~clock;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
    .load_valid(load_valid), .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brd;
    int          rdy_wait;
    logic        rsp_en;
    logic        exp_fault;
    logic [1:0]  exp_cause;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
    int          exp_stall;
  } vec_t;

  vec_t        vecs[15];
  vec_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] rdata_hold = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   req_cycles, stall_cycles, handshakes;
    bit   done, hs_now;
    vec_t e;
    exp_q.push_back(v);
    @(posedge clock); #1;
    mem_read      = v.rd;
    mem_write     = v.wr;
    funct3        = v.f3;
    addr          = v.addr;
    wdata         = v.wdata;
    bus_rdata     = v.brd;
    bus_req_ready = (v.rdy_wait == 0);
    bus_rsp_valid = 1'b0;
    req_cycles = 0; stall_cycles = 0; handshakes = 0; done = 0; hs_now = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clock);
      if (bus_req_valid) begin
        req_cycles++;
        check("bus_we", 32'(bus_we), 32'(exp_q[0].exp_we));
        check("bus_addr", bus_addr, {exp_q[0].addr[31:2], 2'b00});
        check("bus_wdata", bus_wdata, exp_q[0].exp_wdata);
        check("bus_wstrb", 32'(bus_wstrb), 32'(exp_q[0].exp_wstrb));
      end
      hs_now = bus_req_valid && bus_req_ready;
      if (hs_now) handshakes++;
      if (stall) begin
        stall_cycles++;
      end else begin
        done = 1;
        e = exp_q.pop_front();
        check("fault", 32'(fault), 32'(e.exp_fault));
        check("fault_cause", 32'(fault_cause), 32'(e.exp_cause));
        check("load_valid", 32'(load_valid), 32'(!e.exp_fault && !e.wr));
        if (!e.exp_fault && !e.wr) rdata_hold = e.exp_rdata;
        check("rdata", rdata, rdata_hold);
        check("stall_cycles", 32'(stall_cycles), 32'(e.exp_stall));
        check("bus_handshakes", 32'(handshakes), (e.exp_stall > 0) ? 32'd1 : 32'd0);
      end
      @(posedge clock); #1;
      if (done) begin
        mem_read = 1'b0; mem_write = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
      end else begin
        bus_rsp_valid = hs_now && v.rsp_en;
        bus_req_ready = !hs_now && (handshakes == 0) && (req_cycles >= v.rdy_wait);
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL completion_budget: got no completion expected one within 40 cycles");
      exp_q.delete();
      mem_read = 1'b0; mem_write = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          rd    wr    f3      addr         wdata         brd        rdy rsp   flt   cause           we    exp_wdata      wstrb    exp_rdata    stall
    vecs[0]  = '{1'b1, 1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b1, 1'b0, CAUSE_NONE,     1'b0, 32'h0,        4'b0000, 32'hDEADBEEF, 3};
    vecs[1]  = '{1'b1, 1'b0, F3_B,  32'h103, 32'h0,        32'h80FFFFFF, 0, 1'b1, 1'b0, CAUSE_NONE,     1'b0, 32'h0,        4'b0000, 32'hFFFFFF80, 3};
    vecs[2]  = '{1'b1, 1'b0, F3_BU, 32'h103, 32'h0,        32'h80FFFFFF, 0, 1'b1, 1'b0, CAUSE_NONE,     1'b0, 32'h0,        4'b0000, 32'h00000080, 3};
    vecs[3]  = '{1'b1, 1'b0, F3_HU, 32'h102, 32'h0,        32'h80011234, 0, 1'b1, 1'b0, CAUSE_NONE,     1'b0, 32'h0,        4'b0000, 32'h00008001, 3};
    vecs[4]  = '{1'b1, 1'b0, F3_H,  32'h100, 32'h0,        32'h0000F00D, 0, 1'b1, 1'b0, CAUSE_NONE,     1'b0, 32'h0,        4'b0000, 32'hFFFFF00D, 3};
    vecs[5]  = '{1'b0, 1'b1, F3_B,  32'h201, 32'h000000A5, 32'h0,        0, 1'b1, 1'b0, CAUSE_NONE,     1'b1, 32'hA5A5A5A5, 4'b0010, 32'h0,        3};
    vecs[6]  = '{1'b0, 1'b1, F3_H,  32'h202, 32'h00001234, 32'h0,        0, 1'b1, 1'b0, CAUSE_NONE,     1'b1, 32'h12341234, 4'b1100, 32'h0,        3};
    vecs[7]  = '{1'b0, 1'b1, F3_W,  32'h300, 32'hCAFEF00D, 32'h0,        0, 1'b1, 1'b0, CAUSE_NONE,     1'b1, 32'hCAFEF00D, 4'b1111, 32'h0,        3};
    vecs[8]  = '{1'b1, 1'b0, F3_W,  32'h102, 32'h0,        32'h0,        0, 1'b1, 1'b1, CAUSE_MISALIGN, 1'b0, 32'h0,        4'b0000, 32'h0,        0};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,       32'h0,        0, 1'b1, 1'b1, CAUSE_SIZE,     1'b0, 32'h0,        4'b0000, 32'h0,        0};
    vecs[10] = '{1'b0, 1'b1, F3_BU, 32'h101, 32'h0,        32'h0,        0, 1'b1, 1'b1, CAUSE_SIZE,     1'b1, 32'h0,        4'b0000, 32'h0,        0};
    vecs[11] = '{1'b0, 1'b1, F3_H,  32'h203, 32'h0,        32'h0,        0, 1'b1, 1'b1, CAUSE_MISALIGN, 1'b1, 32'h0,        4'b0000, 32'h0,        0};
    vecs[12] = '{1'b1, 1'b1, F3_B,  32'h200, 32'h0000005A, 32'h0,        0, 1'b1, 1'b0, CAUSE_NONE,     1'b1, 32'h5A5A5A5A, 4'b0001, 32'h0,        3};
    vecs[13] = '{1'b1, 1'b0, F3_W,  32'h400, 32'h0,        32'h11223344, 4, 1'b1, 1'b0, CAUSE_NONE,     1'b0, 32'h0,        4'b0000, 32'h11223344, 7};
    vecs[14] = '{1'b1, 1'b0, F3_W,  32'h500, 32'h0,        32'h55555555, 0, 1'b0, 1'b1, CAUSE_TIMEOUT,  1'b0, 32'h0,        4'b0000, 32'h0,        1 + TO};

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_bus_req_valid", 32'(bus_req_valid), 32'd0);
    check("reset_load_valid", 32'(load_valid), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Asynchronous reset while waiting for a response
    @(posedge clock); #1;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; addr = 32'h600; wdata = '0;
    bus_rdata = 32'h77777777; bus_req_ready = 1'b1; bus_rsp_valid = 1'b0;
    @(negedge clock);
    check("rst_seq_idle_stall", 32'(stall), 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_seq_req_valid", 32'(bus_req_valid), 32'd1);
    @(posedge clock); #1;
    bus_req_ready = 1'b0;
    @(negedge clock);
    check("rst_seq_wait_stall", 32'(stall), 32'd1);
    check("rst_seq_wait_req_valid", 32'(bus_req_valid), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_stall", 32'(stall), 32'd0);
    check("async_rst_req_valid", 32'(bus_req_valid), 32'd0);
    check("async_rst_fault", 32'(fault), 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    check("async_rst_bus_addr", bus_addr, 32'd0);
    rdata_hold = '0;
    mem_read = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus_rsp_valid = 1'b1;
    @(negedge clock);
    check("stray_rsp_stall", 32'(stall), 32'd0);
    check("stray_rsp_load_valid", 32'(load_valid), 32'd0);
    @(posedge clock); #1;
    bus_rsp_valid = 1'b0;
    @(negedge clock);
    check("stray_rsp_load_valid_next", 32'(load_valid), 32'd0);
    check("stray_rsp_rdata", rdata, 32'd0);

    run_vec('{1'b1, 1'b0, F3_W, 32'h700, 32'h0, 32'h0BADCAFE, 0, 1'b1, 1'b0, CAUSE_NONE,
              1'b0, 32'h0, 4'b0000, 32'h0BADCAFE, 3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
